// File: rtl/decode_mux_stage_n.sv
// rtl/decode_mux_stage_n.sv - second-stage decode mux with priority arbitration, immediate normalisation and skid buffer
//
// Purpose:
//   Collects the outputs of NUM_CH parallel format decoders and forwards the
//   lowest-index hitting channel as one registered decoded-instruction bundle.
//   The raw right-aligned immediate is sign/zero extended from a per-channel
//   MSB index, then left shifted, into a full IMM_W immediate.
//   Output side is a valid/ready handshake backed by an output register plus
//   one skid register, so ready_o is a pure flop output.
//
// Ports:
//   clock_i, resetn_i        clock, synchronous active-low reset
//   instructionAddress_i     address of the instruction in flight
//   opcode_i                 primary opcode
//   chEnable_i               per-channel hit, bit i = channel i
//   chFormat_i               format code per channel, channel 0 in the MSBs
//   chReg_i / chRegEn_i      reg1..reg3 specifiers and enables, channel i at slice i
//   chImm_i                  raw immediate, channel i at slice i
//   chImmMsb_i               immediate MSB index (field width - 1), channel i at slice i
//   chImmSigned_i            1 = sign-extend, 0 = zero-extend
//   chImmShift_i             left shift 0..63, channel i at slice i
//   chImmEn_i                immediate valid (0 forces imm_o to 0)
//   chPayload_i              opaque passthrough, channel i at slice i
//   ready_o                  stage can accept (skid register empty)
//   valid_o / ready_i        output handshake
//   *_o data outputs         registered bundle of the winning channel
//   channel_o                winning channel index
//
// Configuration:
//   DECODE_CONFLICT_CHECK_EN adds conflict_o (sticky) and conflictCount_o
//   (saturating) reporting accepted cycles with more than one channel hit.

module decode_mux_stage_n #(
    parameter int NUM_CH   = 6,
    parameter int ADDR_W   = 64,
    parameter int OPC_W    = 6,
    parameter int REG_W    = 5,
    parameter int IMM_IN_W = 16,
    parameter int IMM_W    = 64,
    parameter int PAY_W    = 24,
    parameter int FMT_W    = 5,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clock_i,
    input  logic                        resetn_i,
    input  logic [ADDR_W-1:0]           instructionAddress_i,
    input  logic [OPC_W-1:0]            opcode_i,
    input  logic [NUM_CH-1:0]           chEnable_i,
    input  logic [NUM_CH*FMT_W-1:0]     chFormat_i,
    input  logic [NUM_CH*3*REG_W-1:0]   chReg_i,
    input  logic [NUM_CH*3-1:0]         chRegEn_i,
    input  logic [NUM_CH*IMM_IN_W-1:0]  chImm_i,
    input  logic [NUM_CH*4-1:0]         chImmMsb_i,
    input  logic [NUM_CH-1:0]           chImmSigned_i,
    input  logic [NUM_CH*6-1:0]         chImmShift_i,
    input  logic [NUM_CH-1:0]           chImmEn_i,
    input  logic [NUM_CH*PAY_W-1:0]     chPayload_i,
    output logic                        ready_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [ADDR_W-1:0]           instructionAddress_o,
    output logic [OPC_W-1:0]            opcode_o,
    output logic [FMT_W-1:0]            format_o,
    output logic [3*REG_W-1:0]          reg_o,
    output logic [2:0]                  regEn_o,
    output logic [IMM_W-1:0]            imm_o,
    output logic                        immEn_o,
    output logic [PAY_W-1:0]            payload_o,
    output logic [CH_W-1:0]             channel_o
`ifdef DECODE_CONFLICT_CHECK_EN
    ,
    output logic                        conflict_o,
    output logic [15:0]                 conflictCount_o
`endif
);

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [OPC_W-1:0]   opc;
        logic [FMT_W-1:0]   fmt;
        logic [3*REG_W-1:0] regs;
        logic [2:0]         regen;
        logic [IMM_W-1:0]   imm;
        logic               immen;
        logic [PAY_W-1:0]   pay;
        logic [CH_W-1:0]    ch;
    } bundle_t;

    // Extend from bit msb (bits above it in the raw field are discarded),
    // then shift left; bits shifted past IMM_W are lost.
    function automatic logic [IMM_W-1:0] norm_imm(
        input logic [IMM_IN_W-1:0] raw,
        input logic [3:0]          msb,
        input logic                sgn,
        input logic [5:0]          shamt
    );
        logic [IMM_W-1:0] wide;
        logic [IMM_W-1:0] ext;
        logic             fill;
        wide = IMM_W'(raw);
        fill = sgn & raw[msb];
        for (int b = 0; b < IMM_W; b++) begin
            ext[b] = (b <= int'(msb)) ? wide[b] : fill;
        end
        return ext << shamt;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration and bundle assembly
    // ------------------------------------------------------------------
    logic [IMM_IN_W-1:0] sel_raw;
    logic [3:0]          sel_msb;
    logic                sel_sgn;
    logic [5:0]          sel_shamt;
    logic                sel_ien;
    bundle_t             sel_bundle;

    // Scanning from the top down lets the lowest set index overwrite last.
    always_comb begin
        sel_bundle      = '0;
        sel_bundle.addr = instructionAddress_i;
        sel_bundle.opc  = opcode_i;
        sel_raw         = '0;
        sel_msb         = '0;
        sel_sgn         = 1'b0;
        sel_shamt       = '0;
        sel_ien         = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chEnable_i[i]) begin
                sel_bundle.fmt   = chFormat_i[(NUM_CH-1-i)*FMT_W +: FMT_W];
                sel_bundle.regs  = chReg_i[i*3*REG_W +: 3*REG_W];
                sel_bundle.regen = chRegEn_i[i*3 +: 3];
                sel_bundle.pay   = chPayload_i[i*PAY_W +: PAY_W];
                sel_bundle.ch    = CH_W'(i);
                sel_raw          = chImm_i[i*IMM_IN_W +: IMM_IN_W];
                sel_msb          = chImmMsb_i[i*4 +: 4];
                sel_sgn          = chImmSigned_i[i];
                sel_shamt        = chImmShift_i[i*6 +: 6];
                sel_ien          = chImmEn_i[i];
            end
        end
        // Only one normaliser: the selected channel's raw fields feed it.
        sel_bundle.immen = sel_ien;
        sel_bundle.imm   = sel_ien ? norm_imm(sel_raw, sel_msb, sel_sgn, sel_shamt) : '0;
    end

    // ------------------------------------------------------------------
    // Output register + skid register
    // ------------------------------------------------------------------
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    accept;

    // ready_o depends only on the skid flop, never on ready_i.
    assign ready_o = ~skid_valid_q;
    assign accept  = (|chEnable_i) & ready_o;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || ready_i) begin
            // Output slot is free or draining: the skid is older than any
            // new accept, and the two never coexist because a full skid
            // deasserts ready_o.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = sel_bundle;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new bundle so the output holds still.
            skid_d       = sel_bundle;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign valid_o              = out_valid_q;
    assign instructionAddress_o = out_q.addr;
    assign opcode_o             = out_q.opc;
    assign format_o             = out_q.fmt;
    assign reg_o                = out_q.regs;
    assign regEn_o              = out_q.regen;
    assign imm_o                = out_q.imm;
    assign immEn_o              = out_q.immen;
    assign payload_o            = out_q.pay;
    assign channel_o            = out_q.ch;

`ifdef DECODE_CONFLICT_CHECK_EN
    // ------------------------------------------------------------------
    // Multi-hit conflict monitor
    // ------------------------------------------------------------------
    logic        conflict_q, conflict_d;
    logic [15:0] count_q, count_d;
    logic        multi_hit;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi_hit = |(chEnable_i & (chEnable_i - NUM_CH'(1)));

    always_comb begin
        conflict_d = conflict_q;
        count_d    = count_q;
        if (accept && multi_hit) begin
            conflict_d = 1'b1;
            count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            conflict_q <= 1'b0;
            count_q    <= '0;
        end else begin
            conflict_q <= conflict_d;
            count_q    <= count_d;
`ifndef SYNTHESIS
            if (accept && multi_hit) begin
                $display("decode_mux_stage_n: multi-hit, winner ch %0d, enable mask %b",
                         sel_bundle.ch, chEnable_i);
            end
`endif
        end
    end

    assign conflict_o      = conflict_q;
    assign conflictCount_o = count_q;
`endif

endmodule

// File: tb/tb_decode_mux_stage_n.sv
// tb/tb_decode_mux_stage_n.sv - randomized self-checking bench for decode_mux_stage_n
module tb_decode_mux_stage_n;

    localparam int NUM_CH   = 6;
    localparam int ADDR_W   = 64;
    localparam int OPC_W    = 6;
    localparam int REG_W    = 5;
    localparam int IMM_IN_W = 16;
    localparam int IMM_W    = 64;
    localparam int PAY_W    = 24;
    localparam int FMT_W    = 5;
    localparam int CH_W     = 3;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [OPC_W-1:0]   opc;
        logic [FMT_W-1:0]   fmt;
        logic [3*REG_W-1:0] regs;
        logic [2:0]         regen;
        logic [IMM_W-1:0]   imm;
        logic               immen;
        logic [PAY_W-1:0]   pay;
        logic [CH_W-1:0]    ch;
    } bundle_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       resetn;
    logic [ADDR_W-1:0]          addr_i;
    logic [OPC_W-1:0]           opc_i;
    logic [NUM_CH-1:0]          ch_en;
    logic [NUM_CH*FMT_W-1:0]    ch_fmt;
    logic [NUM_CH*3*REG_W-1:0]  ch_reg;
    logic [NUM_CH*3-1:0]        ch_regen;
    logic [NUM_CH*IMM_IN_W-1:0] ch_imm;
    logic [NUM_CH*4-1:0]        ch_msb;
    logic [NUM_CH-1:0]          ch_sgn;
    logic [NUM_CH*6-1:0]        ch_sh;
    logic [NUM_CH-1:0]          ch_ien;
    logic [NUM_CH*PAY_W-1:0]    ch_pay;
    logic                       rdy_i;

    logic                ready_o, valid_o, immEn_o;
    logic [ADDR_W-1:0]   instructionAddress_o;
    logic [OPC_W-1:0]    opcode_o;
    logic [FMT_W-1:0]    format_o;
    logic [3*REG_W-1:0]  reg_o;
    logic [2:0]          regEn_o;
    logic [IMM_W-1:0]    imm_o;
    logic [PAY_W-1:0]    payload_o;
    logic [CH_W-1:0]     channel_o;
`ifdef DECODE_CONFLICT_CHECK_EN
    logic                conflict_o;
    logic [15:0]         conflictCount_o;
`endif

    decode_mux_stage_n dut (
        .clock_i(clk), .resetn_i(resetn),
        .instructionAddress_i(addr_i), .opcode_i(opc_i),
        .chEnable_i(ch_en), .chFormat_i(ch_fmt), .chReg_i(ch_reg), .chRegEn_i(ch_regen),
        .chImm_i(ch_imm), .chImmMsb_i(ch_msb), .chImmSigned_i(ch_sgn), .chImmShift_i(ch_sh),
        .chImmEn_i(ch_ien), .chPayload_i(ch_pay),
        .ready_o(ready_o), .valid_o(valid_o), .ready_i(rdy_i),
        .instructionAddress_o(instructionAddress_o), .opcode_o(opcode_o), .format_o(format_o),
        .reg_o(reg_o), .regEn_o(regEn_o), .imm_o(imm_o), .immEn_o(immEn_o),
        .payload_o(payload_o), .channel_o(channel_o)
`ifdef DECODE_CONFLICT_CHECK_EN
        , .conflict_o(conflict_o), .conflictCount_o(conflictCount_o)
`endif
    );

    bundle_t dut_bundle;
    assign dut_bundle = {instructionAddress_o, opcode_o, format_o, reg_o, regEn_o,
                         imm_o, immEn_o, payload_o, channel_o};

    int checks = 0;
    int errors = 0;
    bundle_t exp_q[$];
    logic [ADDR_W-1:0] got_q[$];
    int conf_cnt = 0;

    // Reference immediate: mask the field to msb+1 bits, subtract 2^(msb+1)
    // when the sign bit is set, then shift.
    function automatic logic [63:0] ref_imm(logic [15:0] raw, int msb, logic sgn, int sh, logic en);
        logic [63:0] span, v;
        span = 64'd1 << (msb + 1);
        v = {48'd0, raw} & (span - 64'd1);
        if (sgn && ((v >> msb) & 64'd1) != 64'd0) v = v - span;
        if (!en) return 64'd0;
        return v << sh;
    endfunction

    function automatic bundle_t ref_bundle();
        bundle_t b;
        int c;
        c = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_en[i]) begin
                c = i;
                break;
            end
        end
        b.addr  = addr_i;
        b.opc   = opc_i;
        b.fmt   = ch_fmt[(NUM_CH-1-c)*FMT_W +: FMT_W];
        b.regs  = ch_reg[c*3*REG_W +: 3*REG_W];
        b.regen = ch_regen[c*3 +: 3];
        b.immen = ch_ien[c];
        b.imm   = ref_imm(ch_imm[c*16 +: 16], int'(ch_msb[c*4 +: 4]), ch_sgn[c],
                          int'(ch_sh[c*6 +: 6]), ch_ien[c]);
        b.pay   = ch_pay[c*PAY_W +: PAY_W];
        b.ch    = CH_W'(c);
        return b;
    endfunction

    task automatic rand_fields();
        addr_i = {$urandom, $urandom};
        opc_i  = OPC_W'($urandom);
        for (int c = 0; c < NUM_CH; c++) begin
            ch_fmt[c*FMT_W +: FMT_W]       = FMT_W'($urandom);
            ch_reg[c*3*REG_W +: 3*REG_W]   = 15'($urandom);
            ch_regen[c*3 +: 3]             = 3'($urandom);
            ch_imm[c*16 +: 16]             = 16'($urandom);
            ch_msb[c*4 +: 4]               = 4'($urandom);
            ch_sgn[c]                      = 1'($urandom);
            ch_sh[c*6 +: 6]                = 6'($urandom);
            ch_ien[c]                      = 1'($urandom);
            ch_pay[c*PAY_W +: PAY_W]       = PAY_W'($urandom);
        end
    endtask

    task automatic set_imm(int c, logic [15:0] raw, logic [3:0] msb, logic sgn, logic [5:0] sh, logic ien);
        ch_imm[c*16 +: 16] = raw;
        ch_msb[c*4 +: 4]   = msb;
        ch_sgn[c]          = sgn;
        ch_sh[c*6 +: 6]    = sh;
        ch_ien[c]          = ien;
    endtask

    // Advance one clock with the current inputs, updating the FIFO model.
    // Called and returns at a negedge, so outputs are stable for checking.
    task automatic drive_step();
        logic acc, drn;
        bundle_t head;
        if (!resetn) begin
            @(posedge clk);
            exp_q.delete();
            conf_cnt = 0;
            @(negedge clk);
            return;
        end
        acc = (|ch_en) && ready_o;
        drn = valid_o && rdy_i;
        if (drn) begin
            got_q.push_back(instructionAddress_o);
            if (exp_q.size() > 0) head = exp_q.pop_front();
        end
        if (acc) begin
            exp_q.push_back(ref_bundle());
            if ($countones(ch_en) > 1 && conf_cnt < 65535) conf_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; rdy_i = 1'b1; ch_en = '0;
        rand_fields();
        drive_step();
        drive_step();
        resetn = 1'b1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", ready_o); end
        checks++; if (dut_bundle !== '0) begin errors++; $display("FAIL reset_data: got %h exp 0", dut_bundle); end
`ifdef DECODE_CONFLICT_CHECK_EN
        checks++; if (conflict_o !== 1'b0 || conflictCount_o !== 16'd0) begin
            errors++; $display("FAIL reset_conflict: got %b/%0d exp 0/0", conflict_o, conflictCount_o); end
`endif
    endtask

    task automatic test_single();
        rand_fields();
        set_imm(2, 16'h8000, 4'd15, 1'b1, 6'd0, 1'b1);
        ch_en = 6'b000100; rdy_i = 1'b1;
        drive_step();
        ch_en = '0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", valid_o); end
        checks++; if (channel_o !== 3'd2) begin errors++; $display("FAIL single_channel: got %0d exp 2", channel_o); end
        checks++; if (imm_o !== 64'hFFFF_FFFF_FFFF_8000) begin
            errors++; $display("FAIL single_imm: got %h exp ffffffffffff8000", imm_o); end
        checks++; if (exp_q.size() != 1 || dut_bundle !== exp_q[0]) begin
            errors++; $display("FAIL single_bundle: got %h (model depth %0d)", dut_bundle, exp_q.size()); end
        drive_step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_drain: got %b exp 0", valid_o); end
    endtask

    task automatic test_imm();
        logic [15:0] raws [7];
        logic [3:0]  msbs [7];
        logic        sgns [7];
        logic [5:0]  shs  [7];
        logic        iens [7];
        logic [63:0] exps [7];
        int c;
        raws = '{16'h0FFF, 16'h0FFF, 16'hAFFF, 16'h0001, 16'h8000, 16'h0001, 16'h7FFF};
        msbs = '{4'd11, 4'd11, 4'd11, 4'd15, 4'd15, 4'd0, 4'd15};
        sgns = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        shs  = '{6'd4, 6'd4, 6'd4, 6'd63, 6'd0, 6'd0, 6'd8};
        iens = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exps = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_FFF0, 64'hFFFF_FFFF_FFFF_FFF0,
                 64'h8000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_007F_FF00};
        for (int k = 0; k < 7; k++) begin
            c = $urandom_range(0, NUM_CH - 1);
            rand_fields();
            set_imm(c, raws[k], msbs[k], sgns[k], shs[k], iens[k]);
            ch_en = NUM_CH'(1) << c; rdy_i = 1'b1;
            drive_step();
            ch_en = '0;
            checks++; if (imm_o !== exps[k] || immEn_o !== iens[k]) begin
                errors++; $display("FAIL imm_case%0d: got %h/%b exp %h/%b", k, imm_o, immEn_o, exps[k], iens[k]); end
            checks++; if (exp_q.size() != 1 || dut_bundle !== exp_q[0]) begin
                errors++; $display("FAIL imm_bundle%0d: got %h (model depth %0d)", k, dut_bundle, exp_q.size()); end
            drive_step();
        end
    endtask

    task automatic test_back_to_back();
        logic c_taken;
        got_q.delete();
        rand_fields();
        rdy_i = 1'b0;
        addr_i = 64'hA; ch_en = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
        drive_step();
        addr_i = 64'hB; ch_en = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
        drive_step();
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b exp 0", ready_o); end
        addr_i = 64'hC; ch_en = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
        drive_step();
        drive_step();
        checks++; if (valid_o !== 1'b1 || instructionAddress_o !== 64'hA || ready_o !== 1'b0) begin
            errors++; $display("FAIL bp_hold: got v%b a%h r%b exp v1 aa r0", valid_o, instructionAddress_o, ready_o); end
        checks++; if (dut_bundle !== exp_q[0]) begin
            errors++; $display("FAIL bp_hold_bundle: got %h exp %h", dut_bundle, exp_q[0]); end
        rdy_i = 1'b1;
        c_taken = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (ready_o === 1'b1 && ch_en != '0) c_taken = 1'b1;
            drive_step();
            if (c_taken) ch_en = '0;
            checks++; if (valid_o !== (exp_q.size() > 0) || ready_o !== (exp_q.size() < 2)) begin
                errors++; $display("FAIL bp_flags: got v%b r%b model depth %0d", valid_o, ready_o, exp_q.size()); end
            if (valid_o === 1'b1 && exp_q.size() > 0) begin
                checks++; if (dut_bundle !== exp_q[0]) begin
                    errors++; $display("FAIL bp_bundle: got %h exp %h", dut_bundle, exp_q[0]); end
            end
        end
        checks++; if (got_q.size() != 3) begin
            errors++; $display("FAIL bp_count: got %0d delivered exp 3", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 64'hA || got_q[1] !== 64'hB || got_q[2] !== 64'hC) begin
                errors++; $display("FAIL bp_order: got %h %h %h exp a b c", got_q[0], got_q[1], got_q[2]); end
        end
    endtask

    task automatic test_priority();
        rand_fields();
        ch_en = 6'b101100; rdy_i = 1'b1;
        drive_step();
        ch_en = '0;
        checks++; if (channel_o !== 3'd2) begin errors++; $display("FAIL prio_channel: got %0d exp 2", channel_o); end
        checks++; if (exp_q.size() != 1 || dut_bundle !== exp_q[0]) begin
            errors++; $display("FAIL prio_bundle: got %h (model depth %0d)", dut_bundle, exp_q.size()); end
`ifdef DECODE_CONFLICT_CHECK_EN
        checks++; if (conflict_o !== 1'b1 || conflictCount_o !== 16'd1) begin
            errors++; $display("FAIL prio_conflict: got %b/%0d exp 1/1", conflict_o, conflictCount_o); end
`endif
        drive_step();
    endtask

    task automatic test_mid_reset();
        rand_fields();
        rdy_i = 1'b0; ch_en = 6'b110000;
        drive_step();
        addr_i = 64'h1234; drive_step();
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mr_skid_full: got ready %b exp 0", ready_o); end
        resetn = 1'b0;
        drive_step();
        resetn = 1'b1; ch_en = '0;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL mr_flags: got v%b r%b exp v0 r1", valid_o, ready_o); end
`ifdef DECODE_CONFLICT_CHECK_EN
        checks++; if (conflict_o !== 1'b0 || conflictCount_o !== 16'd0) begin
            errors++; $display("FAIL mr_conflict: got %b/%0d exp 0/0", conflict_o, conflictCount_o); end
`endif
        got_q.delete();
        rand_fields();
        addr_i = 64'hD00D; ch_en = 6'b001000; rdy_i = 1'b1;
        drive_step();
        ch_en = '0;
        checks++; if (valid_o !== 1'b1 || instructionAddress_o !== 64'hD00D) begin
            errors++; $display("FAIL mr_new: got v%b a%h exp v1 ad00d", valid_o, instructionAddress_o); end
        drive_step();
        drive_step();
        checks++; if (got_q.size() != 1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL mr_only_new: got %0d delivered v%b exp 1 v0", got_q.size(), valid_o); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rand_fields();
            ch_en = ($urandom_range(0, 3) == 0) ? '0 : NUM_CH'($urandom);
            rdy_i = ($urandom_range(0, 3) != 0);
            drive_step();
            checks++; if (valid_o !== (exp_q.size() > 0) || ready_o !== (exp_q.size() < 2)) begin
                errors++; $display("FAIL rand_flags@%0d: got v%b r%b model depth %0d", cyc, valid_o, ready_o, exp_q.size()); end
            if (exp_q.size() > 0) begin
                checks++; if (dut_bundle !== exp_q[0]) begin
                    errors++; $display("FAIL rand_bundle@%0d: got %h exp %h", cyc, dut_bundle, exp_q[0]); end
            end
`ifdef DECODE_CONFLICT_CHECK_EN
            checks++; if (conflictCount_o !== 16'(conf_cnt) || conflict_o !== (conf_cnt > 0)) begin
                errors++; $display("FAIL rand_conflict@%0d: got %b/%0d exp count %0d", cyc, conflict_o, conflictCount_o, conf_cnt); end
`endif
        end
        ch_en = '0; rdy_i = 1'b1;
        for (int k = 0; k < 4; k++) drive_step();
        checks++; if (valid_o !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_drain: got v%b model depth %0d exp v0 depth 0", valid_o, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_imm();
        test_back_to_back();
        test_priority();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
